dstage_param: RTL and testbench
===============================

# dstage_param

Parametrised decode-stage datapath for the pipelined MIPS core, placed between the F/D and D/E pipeline registers. Holds the general register file, selects operands from the register file or from NFWD forwarding sources, resolves branches and jumps in D, and owns the D/E pipeline register with its stall, flush and delay-slot tracking. It generalises the fixed 32x32, two-source decode stage to configurable width, register count and forwarding depth.

## Interface
- XLEN, 32, data/PC width in bits (>= 16)
- NREG, 32, number of architectural registers (power of two, >= 2); AW = $clog2(NREG)
- NFWD, 2, number of forwarding sources; FSW = $clog2(NFWD+1)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  F/D register holds a valid instruction
- in_pc / in_instr  input  XLEN / 32  PC and instruction word in D
- in_exc  input  5  exception code from F (0 = none)
- rs_addr / rt_addr  input  AW  source register indices
- br_op  input  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 jr
- fwd_sel_rs / fwd_sel_rt  input  FSW  0 = register file, k = source k
- fwd_data  input  NFWD*XLEN  forwarding values; source k at [k*XLEN-1 -: XLEN]
- hcu_stall / d_flush  input  1  hazard-unit stall; pipeline flush
- w_we / w_addr / w_data  input  1 / AW / XLEN  write-back port
- d_ready  output  1  = !hcu_stall; F/D register may advance
- redirect / redirect_pc  output  1 / XLEN  taken branch/jump and target
- d_is_bd  output  1  current D instruction is a delay-slot instruction
- e_valid, e_pc, e_instr, e_rs_val, e_rt_val, e_exc, e_bd  output  1, XLEN, 32, XLEN, XLEN, 5, 1  D/E register

## Operation
- Register file: NREG x XLEN; write on rising edge when w_we and w_addr != 0; register 0 reads 0.
- Operand value = fwd_data source fwd_sel when 1 <= fwd_sel <= NFWD, otherwise register-file read value (sel > NFWD treated as 0).
- accept = in_valid & !hcu_stall & !d_flush.
- Branch compare on signed XLEN operands: beq rs==rt, bne rs!=rt, blez rs<=0, bgtz rs>0, bltz rs<0, bgez rs>=0; jr always taken.
- redirect = accept & taken; redirect_pc = in_pc + 4 + (sext(in_instr[15:0]) << 2), or rs operand for jr; arithmetic modulo 2^XLEN.
- Delay-slot tracker bd_pending: set on accept with br_op != 0, cleared on accept with br_op == 0; cleared by d_flush. d_is_bd = bd_pending.
- D/E register priority: reset > d_flush > hcu_stall > accept.
  - d_flush or hcu_stall: e_valid <= 0, e_instr <= 0 (bubble); other fields don't-care but driven 0.
  - accept: e_valid <= 1, fields <= in_pc, in_instr, selected operands, in_exc, bd_pending.
  - !in_valid, no stall/flush: bubble.
- A branch accepted with bd_pending already 1 (branch in delay slot) keeps bd_pending = 1.

## Timing
- Reset (reset low, asynchronous): all registers incl. register file = 0, e_* = 0, bd_pending = 0.
- Operand select, compare, redirect, d_ready: combinational, same cycle.
- D/E register latency: 1 cycle from accept.
- Register-file write visible to D reads the cycle after the write edge (see Configuration).
- Reset deasserted mid-cycle: state leaves reset on the next rising edge only.

## Configuration
- DSTAGE_WB_BYPASS_EN defined: register-file read returns w_data when w_we & w_addr == read address & w_addr != 0 (write-through in the same cycle).
- Undefined: same-cycle read returns the old stored value; hazard unit must forward W via fwd_data.

## Test plan
- Reset low with in_valid=1 -> all e_* = 0, d_is_bd = 0; reading r5 after release returns 0.
- w_we=1, w_addr=5, w_data=0x1234, rs_addr=5 same cycle -> e_rs_val = 0x1234 next edge with DSTAGE_WB_BYPASS_EN, old value 0 without; w_addr=0 write leaves r0 = 0.
- fwd_sel_rs=2, source 2 = 0xDEAD, rt forwarded source 1 = 0xBEEF -> e_rs_val=0xDEAD, e_rt_val=0xBEEF; fwd_sel_rs=3 (NFWD=2) -> register-file value.
- beq, rs=rt=7, in_pc=0x3000, imm=0xFFFF -> redirect=1, redirect_pc=0x3000; next accepted instruction has d_is_bd=1 and e_bd=1; bne same operands -> redirect=0.
- hcu_stall=1 with valid beq taken -> redirect=0, d_ready=0, e_valid=0 next edge; bd_pending unchanged.
- d_flush=1 while bd_pending=1 -> e_valid=0, d_is_bd=0 next cycle; jr with rs=0x4000 -> redirect_pc=0x4000.

Source files
------------

// File: rtl/dstage_param.sv
// Parametrised MIPS decode stage: register file, operand forwarding, branch resolution, D/E register.
// Optional macro DSTAGE_WB_BYPASS_EN: same-cycle write-through from the write-back port to the read ports.
module dstage_param #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NFWD = 2,
  localparam int AW   = $clog2(NREG),
  localparam int FSW  = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  input  logic [4:0]           in_exc,
  input  logic [AW-1:0]        rs_addr,
  input  logic [AW-1:0]        rt_addr,
  input  logic [2:0]           br_op,
  input  logic [FSW-1:0]       fwd_sel_rs,
  input  logic [FSW-1:0]       fwd_sel_rt,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 hcu_stall,
  input  logic                 d_flush,
  input  logic                 w_we,
  input  logic [AW-1:0]        w_addr,
  input  logic [XLEN-1:0]      w_data,
  output logic                 d_ready,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 d_is_bd,
  output logic                 e_valid,
  output logic [XLEN-1:0]      e_pc,
  output logic [31:0]          e_instr,
  output logic [XLEN-1:0]      e_rs_val,
  output logic [XLEN-1:0]      e_rt_val,
  output logic [4:0]           e_exc,
  output logic                 e_bd
);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_JR   = 3'd7
  } br_op_e;

  logic [XLEN-1:0] r_rf [NREG];
  logic            r_bd_pending;
  logic            r_e_valid;
  logic [XLEN-1:0] r_e_pc;
  logic [31:0]     r_e_instr;
  logic [XLEN-1:0] r_e_rs_val;
  logic [XLEN-1:0] r_e_rt_val;
  logic [4:0]      r_e_exc;
  logic            r_e_bd;

  logic [XLEN-1:0] w_rf_rs;
  logic [XLEN-1:0] w_rf_rt;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic            w_accept;
  logic            w_taken;
  logic signed [31:0] w_off32;
  logic [XLEN-1:0] w_offset;

  // NOTE: the register file is reset like any other state so that reads after
  // reset are defined; this costs a reset net per entry but removes X propagation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_we && (w_addr != '0)) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      r_rf[w_addr] <= w_data;
    end
  end

`ifdef DSTAGE_WB_BYPASS_EN
  assign w_rf_rs = (rs_addr == '0) ? '0 :
                   (w_we && (w_addr == rs_addr)) ? w_data : r_rf[rs_addr];
  assign w_rf_rt = (rt_addr == '0) ? '0 :
                   (w_we && (w_addr == rt_addr)) ? w_data : r_rf[rt_addr];
`else
  assign w_rf_rs = (rs_addr == '0) ? '0 : r_rf[rs_addr];
  assign w_rf_rt = (rt_addr == '0) ? '0 : r_rf[rt_addr];
`endif

  // Selectors outside 1..NFWD fall back to the register file.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable
    // unassigned, which would otherwise infer a latch.
    w_rs_val = w_rf_rs;
    w_rt_val = w_rf_rt;
    for (int k = 1; k <= NFWD; k++) begin
      if (fwd_sel_rs == FSW'(k)) w_rs_val = fwd_data[k*XLEN-1 -: XLEN];
      if (fwd_sel_rt == FSW'(k)) w_rt_val = fwd_data[k*XLEN-1 -: XLEN];
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (br_op_e'(br_op))
      BR_BEQ:  w_taken = (w_rs_val == w_rt_val);
      BR_BNE:  w_taken = (w_rs_val != w_rt_val);
      BR_BLEZ: w_taken = ($signed(w_rs_val) <= 0);
      BR_BGTZ: w_taken = ($signed(w_rs_val) >  0);
      BR_BLTZ: w_taken = ($signed(w_rs_val) <  0);
      BR_BGEZ: w_taken = ($signed(w_rs_val) >= 0);
      BR_JR:   w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  // Offset is built at 32 bits then sign-extended or truncated to XLEN.
  assign w_off32     = {{14{in_instr[15]}}, in_instr[15:0], 2'b00};
  assign w_offset    = XLEN'(w_off32);
  assign w_accept    = in_valid && !hcu_stall && !d_flush;
  assign d_ready     = !hcu_stall;
  assign redirect    = w_accept && w_taken;
  assign redirect_pc = (br_op_e'(br_op) == BR_JR) ? w_rs_val
                                                  : in_pc + XLEN'(4) + w_offset;
  assign d_is_bd     = r_bd_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bd_pending <= 1'b0;
    end else if (d_flush) begin
      r_bd_pending <= 1'b0;
    end else if (w_accept) begin
      r_bd_pending <= (br_op != 3'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_valid  <= 1'b0;
      r_e_pc     <= '0;
      r_e_instr  <= '0;
      r_e_rs_val <= '0;
      r_e_rt_val <= '0;
      r_e_exc    <= '0;
      r_e_bd     <= 1'b0;
    end else if (w_accept) begin
      r_e_valid  <= 1'b1;
      r_e_pc     <= in_pc;
      r_e_instr  <= in_instr;
      r_e_rs_val <= w_rs_val;
      r_e_rt_val <= w_rt_val;
      r_e_exc    <= in_exc;
      r_e_bd     <= r_bd_pending;
    end else begin
      // Flush, stall and idle all insert a fully zeroed bubble.
      r_e_valid  <= 1'b0;
      r_e_pc     <= '0;
      r_e_instr  <= '0;
      r_e_rs_val <= '0;
      r_e_rt_val <= '0;
      r_e_exc    <= '0;
      r_e_bd     <= 1'b0;
    end
  end

  assign e_valid  = r_e_valid;
  assign e_pc     = r_e_pc;
  assign e_instr  = r_e_instr;
  assign e_rs_val = r_e_rs_val;
  assign e_rt_val = r_e_rt_val;
  assign e_exc    = r_e_exc;
  assign e_bd     = r_e_bd;

endmodule

// File: tb/tb_dstage_param.sv
// Directed bench for dstage_param (default parameters): reset, register file, forwarding,
// branch resolution, stall/flush and delay-slot tracking.
module tb_dstage_param;

  localparam int XLEN = 32;
  localparam int NFWD = 2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  in_exc;
  logic [4:0]  rs_addr, rt_addr;
  logic [2:0]  br_op;
  logic [1:0]  fwd_sel_rs, fwd_sel_rt;
  logic [63:0] fwd_data;
  logic        hcu_stall, d_flush;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        d_ready, redirect, d_is_bd;
  logic [31:0] redirect_pc;
  logic        e_valid, e_bd;
  logic [31:0] e_pc, e_instr, e_rs_val, e_rt_val;
  logic [4:0]  e_exc;

  int n_checks = 0;
  int n_errors = 0;

  dstage_param #(.XLEN(XLEN), .NREG(32), .NFWD(NFWD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_exc(in_exc), .rs_addr(rs_addr), .rt_addr(rt_addr), .br_op(br_op),
    .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .fwd_data(fwd_data),
    .hcu_stall(hcu_stall), .d_flush(d_flush), .w_we(w_we), .w_addr(w_addr),
    .w_data(w_data), .d_ready(d_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .d_is_bd(d_is_bd), .e_valid(e_valid), .e_pc(e_pc), .e_instr(e_instr),
    .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .e_exc(e_exc), .e_bd(e_bd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [2:0]  br;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic        stall;
    logic        flush;
    logic        x_redir;
    logic [31:0] x_rpc;
    logic        x_bd;
    logic        x_ev;
    logic [31:0] x_rs;
    logic [31:0] x_rt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(
    input logic v, input logic [31:0] pc, input logic [31:0] instr,
    input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] br,
    input logic [1:0] frs, input logic [1:0] frt, input logic st, input logic fl,
    input logic xr, input logic [31:0] xrpc, input logic xbd, input logic xev,
    input logic [31:0] xrs, input logic [31:0] xrt);
    vec_t t;
    t.valid = v;  t.pc = pc;  t.instr = instr;  t.rs = rs;  t.rt = rt;  t.br = br;
    t.frs = frs;  t.frt = frt;  t.stall = st;  t.flush = fl;
    t.x_redir = xr;  t.x_rpc = xrpc;  t.x_bd = xbd;  t.x_ev = xev;
    t.x_rs = xrs;  t.x_rt = xrt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b0;
    w_we = 1'b1;  w_addr = a;  w_data = d;
    @(posedge clk);
    @(negedge clk);
    w_we = 1'b0;
  endtask

  initial begin
    logic [31:0] x_wb;
    // r3 = 0x100, r4 = -5, r7 = 7, r9 = 0x4000 are preloaded before the table.
    vecs[0]  = mk(1, 32'h1000, 32'h0000_0001, 3, 4, 0, 0, 0, 0, 0, 0, 32'h1008, 0, 1, 32'h100, 32'hFFFF_FFFB);
    vecs[1]  = mk(1, 32'h1004, 32'h0000_0000, 3, 4, 0, 2, 1, 0, 0, 0, 32'h1008, 0, 1, 32'hDEAD, 32'hBEEF);
    vecs[2]  = mk(1, 32'h1008, 32'h0000_0000, 3, 4, 0, 3, 0, 0, 0, 0, 32'h100C, 0, 1, 32'h100, 32'hFFFF_FFFB);
    vecs[3]  = mk(1, 32'h3000, 32'h1000_FFFF, 7, 7, 1, 0, 0, 0, 0, 1, 32'h3000, 0, 1, 32'h7, 32'h7);
    vecs[4]  = mk(1, 32'h3004, 32'h0000_0000, 3, 4, 0, 0, 0, 0, 0, 0, 32'h3008, 1, 1, 32'h100, 32'hFFFF_FFFB);
    vecs[5]  = mk(1, 32'h3008, 32'h1400_FFFF, 7, 7, 2, 0, 0, 0, 0, 0, 32'h3008, 0, 1, 32'h7, 32'h7);
    vecs[6]  = mk(1, 32'h3010, 32'h1000_0002, 7, 7, 1, 0, 0, 1, 0, 0, 32'h301C, 1, 0, 32'h0, 32'h0);
    vecs[7]  = mk(1, 32'h4000, 32'h1800_0010, 4, 0, 3, 0, 0, 0, 0, 1, 32'h4044, 1, 1, 32'hFFFF_FFFB, 32'h0);
    vecs[8]  = mk(1, 32'h5000, 32'h0000_0000, 3, 4, 0, 0, 0, 0, 1, 0, 32'h5004, 1, 0, 32'h0, 32'h0);
    vecs[9]  = mk(1, 32'h5000, 32'h0000_0000, 3, 4, 0, 0, 0, 0, 0, 0, 32'h5004, 0, 1, 32'h100, 32'hFFFF_FFFB);
    vecs[10] = mk(1, 32'h6000, 32'h0000_0000, 9, 0, 7, 0, 0, 0, 0, 1, 32'h4000, 0, 1, 32'h4000, 32'h0);
    vecs[11] = mk(0, 32'h6004, 32'h0000_0000, 3, 4, 0, 0, 0, 0, 0, 0, 32'h6008, 1, 0, 32'h0, 32'h0);
    vecs[12] = mk(1, 32'h7000, 32'h1C00_0001, 4, 0, 4, 0, 0, 0, 0, 0, 32'h7008, 1, 1, 32'hFFFF_FFFB, 32'h0);
    vecs[13] = mk(1, 32'h7004, 32'h0400_0003, 4, 0, 5, 0, 0, 0, 0, 1, 32'h7014, 1, 1, 32'hFFFF_FFFB, 32'h0);
    vecs[14] = mk(1, 32'h8000, 32'h0400_FFFE, 0, 0, 6, 0, 0, 0, 0, 1, 32'h7FFC, 1, 1, 32'h0, 32'h0);
    vecs[15] = mk(1, 32'h8004, 32'h0000_0000, 7, 0, 4, 0, 0, 0, 0, 1, 32'h8008, 1, 1, 32'h7, 32'h0);
    vecs[16] = mk(1, 32'h9000, 32'h1800_0000, 0, 0, 3, 0, 0, 0, 0, 1, 32'h9004, 1, 1, 32'h0, 32'h0);
    vecs[17] = mk(1, 32'h9004, 32'h0000_0000, 3, 4, 1, 0, 0, 0, 0, 0, 32'h9008, 1, 1, 32'h100, 32'hFFFF_FFFB);
    vecs[18] = mk(1, 32'hA000, 32'h0000_0000, 3, 4, 0, 0, 0, 0, 0, 0, 32'hA004, 1, 1, 32'h100, 32'hFFFF_FFFB);
    vecs[19] = mk(1, 32'hA004, 32'h0000_0000, 4, 0, 6, 0, 0, 0, 0, 0, 32'hA008, 0, 1, 32'hFFFF_FFFB, 32'h0);

    // Reset held low with a valid taken branch on the inputs.
    reset = 1'b0;  in_valid = 1'b1;  in_pc = 32'h100;  in_instr = 32'h1000_FFFF;  in_exc = 5'd3;
    rs_addr = 5'd0;  rt_addr = 5'd0;  br_op = 3'd1;  fwd_sel_rs = 2'd0;  fwd_sel_rt = 2'd0;
    fwd_data = {32'h0000_DEAD, 32'h0000_BEEF};
    hcu_stall = 1'b0;  d_flush = 1'b0;  w_we = 1'b0;  w_addr = 5'd0;  w_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst e_valid", e_valid, 0);
    check("rst e_pc", e_pc, 0);
    check("rst e_instr", e_instr, 0);
    check("rst e_exc", e_exc, 0);
    check("rst e_bd", e_bd, 0);
    check("rst d_is_bd", d_is_bd, 0);
    @(negedge clk);
    reset = 1'b1;

    // r5 reads 0 after reset.
    in_valid = 1'b1;  br_op = 3'd0;  in_instr = 32'h0;  rs_addr = 5'd5;
    @(posedge clk); #1;
    check("r5 after reset e_valid", e_valid, 1);
    check("r5 after reset", e_rs_val, 0);
    @(negedge clk);

    // Same-cycle write and read of r5.
`ifdef DSTAGE_WB_BYPASS_EN
    x_wb = 32'h1234;
`else
    x_wb = 32'h0;
`endif
    w_we = 1'b1;  w_addr = 5'd5;  w_data = 32'h1234;
    @(posedge clk); #1;
    check("same-cycle wb read", e_rs_val, x_wb);
    @(negedge clk);
    w_we = 1'b0;
    @(posedge clk); #1;
    check("r5 after write", e_rs_val, 32'h1234);
    @(negedge clk);

    // Writes to r0 are dropped.
    rf_write(5'd0, 32'h55);
    in_valid = 1'b1;  rs_addr = 5'd0;
    @(posedge clk); #1;
    check("r0 stays zero", e_rs_val, 0);
    @(negedge clk);

    rf_write(5'd3, 32'h100);
    rf_write(5'd4, 32'hFFFF_FFFB);
    rf_write(5'd7, 32'h7);
    rf_write(5'd9, 32'h4000);

    for (int i = 0; i < 20; i++) begin
      in_valid = vecs[i].valid;  in_pc = vecs[i].pc;  in_instr = vecs[i].instr;
      in_exc = 5'(i + 1);  rs_addr = vecs[i].rs;  rt_addr = vecs[i].rt;  br_op = vecs[i].br;
      fwd_sel_rs = vecs[i].frs;  fwd_sel_rt = vecs[i].frt;
      hcu_stall = vecs[i].stall;  d_flush = vecs[i].flush;
      #1;
      check($sformatf("v%0d redirect", i), redirect, vecs[i].x_redir);
      check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].x_rpc);
      check($sformatf("v%0d d_ready", i), d_ready, !vecs[i].stall);
      check($sformatf("v%0d d_is_bd", i), d_is_bd, vecs[i].x_bd);
      @(posedge clk); #1;
      check($sformatf("v%0d e_valid", i), e_valid, vecs[i].x_ev);
      check($sformatf("v%0d e_pc", i), e_pc, vecs[i].x_ev ? vecs[i].pc : 32'h0);
      check($sformatf("v%0d e_instr", i), e_instr, vecs[i].x_ev ? vecs[i].instr : 32'h0);
      check($sformatf("v%0d e_rs_val", i), e_rs_val, vecs[i].x_rs);
      check($sformatf("v%0d e_rt_val", i), e_rt_val, vecs[i].x_rt);
      check($sformatf("v%0d e_exc", i), e_exc, vecs[i].x_ev ? 32'(i + 1) : 32'h0);
      check($sformatf("v%0d e_bd", i), e_bd, vecs[i].x_ev ? vecs[i].x_bd : 1'b0);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle with bd_pending set, then the register file reads clear.
    hcu_stall = 1'b0;  d_flush = 1'b0;  fwd_sel_rs = 2'd0;  fwd_sel_rt = 2'd0;
    reset = 1'b0;
    #1;
    check("async rst e_valid", e_valid, 0);
    check("async rst d_is_bd", d_is_bd, 0);
    @(negedge clk);
    reset = 1'b1;  in_valid = 1'b1;  rs_addr = 5'd3;  br_op = 3'd0;  in_instr = 32'h0;
    @(posedge clk); #1;
    check("r3 cleared by reset", e_rs_val, 0);
    check("post-reset e_valid", e_valid, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
